// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared AHB transfer codes, controller states and byte-lane helper
package ahb_sram_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;
  typedef enum logic [1:0] {HR_OKAY = 2'b00, HR_ERROR = 2'b01} hresp_e;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_RD_DATA, ST_WR_DATA, ST_WR_HOLD, ST_ERR1, ST_ERR2} ctrl_state_e;
  function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] lo);
    return hsize == HSIZE_BYTE ? 4'b0001 << lo :
           hsize == HSIZE_HALF ? (lo[1] ? 4'b1100 : 4'b0011) :
           hsize == HSIZE_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// ahb_sram_ctrl_if: AHB-Lite slave-side bus bundle
interface ahb_sram_ctrl_if;
  logic        hsel;
  logic        hwrite;
  logic        hready;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  modport master (output hsel, hwrite, hready, hsize, htrans, hburst, haddr, hwdata,
                  input hready_resp, hresp, hrdata);
  modport slave (input hsel, hwrite, hready, hsize, htrans, hburst, haddr, hwdata,
                 output hready_resp, hresp, hrdata);
endinterface

// File: rtl/ahb_sram_lane_gen.sv
// ahb_sram_lane_gen: flags illegal size/alignment and derives SRAM byte enables
module ahb_sram_lane_gen
  import ahb_sram_pkg::*;
(
  input  logic       valid,
  input  logic [2:0] hsize,
  input  logic [1:0] lo,
  output logic       illegal,
  output logic [3:0] be
);
  always_comb begin
    illegal = valid & ((hsize > HSIZE_WORD) | (hsize == HSIZE_HALF & lo[0]) | (hsize == HSIZE_WORD & lo != 2'b00));
    be = byte_en(hsize, lo);
  end
endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave sequencing a single-port synchronous SRAM
module ahb_sram_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic           hclk,
  input  logic           hresetn,
  ahb_sram_ctrl_if.slave ahb,
  output logic           sram_cs,
  output logic           sram_we,
  output logic [3:0]     sram_be,
  output logic [AW-1:0]  sram_addr,
  output logic [31:0]    sram_wdata,
  input  logic [31:0]    sram_rdata
);
  ctrl_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d, be;
  logic          valid, illegal, coll, acc, rd_go, wr_go, wr_ph;
  logic          unused_bits;
  assign unused_bits = ^{ahb.hburst, ahb.haddr[31:AW+2]};
  assign valid = ahb.hsel & ahb.hready & ahb.htrans[1];
  ahb_sram_lane_gen u_lane (
    .valid  (valid),
    .hsize  (ahb.hsize),
    .lo     (ahb.haddr[1:0]),
    .illegal(illegal),
    .be     (be)
  );
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end
  // a read arriving while the SRAM port is busy writing is stalled one cycle
  always_comb begin
    coll    = state_q == ST_WR_DATA & ahb.hsel & ahb.htrans[1] & ~ahb.hwrite;
    acc     = valid & state_q != ST_ERR1 & ~coll;
    rd_go   = acc & ~illegal & ~ahb.hwrite;
    wr_go   = acc & ~illegal & ahb.hwrite;
    state_d = coll               ? ST_WR_HOLD :
              acc & illegal      ? ST_ERR1    :
              wr_go              ? ST_WR_DATA :
              rd_go              ? ST_RD_DATA :
              state_q == ST_ERR1 ? ST_ERR2    : ST_IDLE;
    addr_d  = wr_go ? ahb.haddr[AW+1:2] : addr_q;
    be_d    = wr_go ? be : be_q;
  end
  always_comb begin
    wr_ph           = state_q == ST_WR_DATA;
    ahb.hready_resp = ~(state_q == ST_ERR1 | coll);
    ahb.hresp       = (state_q == ST_ERR1 | state_q == ST_ERR2) ? HR_ERROR : HR_OKAY;
    ahb.hrdata      = state_q == ST_RD_DATA ? sram_rdata : '0;
    sram_cs         = hresetn & (wr_ph | rd_go);
    sram_we         = hresetn & wr_ph;
    sram_be         = wr_ph ? be_q : '0;
    sram_addr       = wr_ph ? addr_q : rd_go ? ahb.haddr[AW+1:2] : '0;
    sram_wdata      = wr_ph ? ahb.hwdata : '0;
  end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: random AHB traffic against a byte-level memory and response model
module tb_ahb_sram_ctrl;
  localparam int AW = 14;
  localparam int REGION = 1 << (AW + 2);
  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  localparam xfer_t IDLE_X = '0;
  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          sram_cs, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic [31:0]   mem [2**AW];
  logic [7:0]    ref_mem [REGION];
  xfer_t         seq[$];
  int            checks = 0, errors = 0;
  int            exp_wr = 0, exp_rd = 0, got_wr = 0, got_rd = 0;
  ahb_sram_ctrl_if bus();
  assign bus.hready = bus.hready_resp;
  ahb_sram_ctrl #(.AW(AW)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .ahb       (bus),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_be   (sram_be),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );
  always #5 hclk = ~hclk;
  always @(posedge hclk) begin
    if (sram_cs && sram_we)
      for (int b = 0; b < 4; b++) if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
    if (sram_cs && sram_we) got_wr <= got_wr + 1;
    if (sram_cs && !sram_we) got_rd <= got_rd + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit act(input xfer_t x);
    return x.sel && x.trans[1];
  endfunction
  function automatic bit legal(input xfer_t x);
    return x.size <= 2 && (x.addr % (32'd1 << x.size)) == 0;
  endfunction
  function automatic xfer_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] trans = 2'b10);
    xfer_t x;
    x.sel = 1'b1; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.data = data;
    return x;
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'(a[AW+1:0]) & ~3;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction
  task automatic apply_write(input xfer_t x);
    for (int b = 0; b < (1 << x.size); b++) begin
      int a;
      a = int'(x.addr[AW+1:0]) + b;
      ref_mem[a] = x.data[8*(a%4) +: 8];
    end
    exp_wr++;
  endtask
  task automatic drive(input xfer_t ap, input xfer_t dp);
    bus.hsel = ap.sel; bus.htrans = ap.trans; bus.hwrite = ap.wr; bus.hsize = ap.size;
    bus.haddr = ap.addr; bus.hburst = 3'b001; bus.hwdata = dp.data;
  endtask
  task automatic check_phase(input xfer_t dp, input int w, input bit coll, input logic [31:0] exp_rdata);
    logic [3:0] ebe;
    ebe = 4'(((1 << (1 << dp.size)) - 1) << (dp.addr % 4));
    if (!act(dp)) begin
      check("idle_ready", 32'(bus.hready_resp), 32'd1);
      check("idle_resp", 32'(bus.hresp), 32'd0);
      check("idle_rdata", bus.hrdata, 32'd0);
    end else if (!legal(dp)) begin
      check("err_ready", 32'(bus.hready_resp), 32'(w != 0));
      check("err_resp", 32'(bus.hresp), 32'd1);
      check("err_rdata", bus.hrdata, 32'd0);
    end else if (dp.wr) begin
      check("wr_resp", 32'(bus.hresp), 32'd0);
      check("wr_rdata", bus.hrdata, 32'd0);
      if (w == 0) begin
        check("wr_ready", 32'(bus.hready_resp), 32'(!coll));
        check("wr_cswe", 32'({sram_cs, sram_we}), 32'd3);
        check("wr_be", 32'(sram_be), 32'(ebe));
        check("wr_addr", 32'(sram_addr), (dp.addr >> 2) % (32'd1 << AW));
        check("wr_wdata", sram_wdata, dp.data);
      end else check("hold_ready", 32'(bus.hready_resp), 32'd1);
    end else begin
      check("rd_ready", 32'(bus.hready_resp), 32'd1);
      check("rd_resp", 32'(bus.hresp), 32'd0);
      check("rd_data", bus.hrdata, exp_rdata);
    end
  endtask
  task automatic run_seq();
    xfer_t dp, ap, nx;
    bit coll, done;
    int i, w;
    logic [31:0] exp_rdata;
    dp = IDLE_X; coll = 0; i = 0; w = 0; exp_rdata = '0;
    while (i <= seq.size()) begin
      ap = i < seq.size() ? seq[i] : IDLE_X;
      drive(ap, dp);
      @(negedge hclk);
      check_phase(dp, w, coll, exp_rdata);
      done = bus.hready_resp;
      @(posedge hclk);
      #1;
      if (done) begin
        nx = i + 1 < seq.size() ? seq[i+1] : IDLE_X;
        coll = act(ap) && legal(ap) && ap.wr && act(nx) && !nx.wr;
        if (act(ap) && legal(ap)) begin
          if (ap.wr) apply_write(ap);
          else begin
            exp_rdata = ref_word(ap.addr);
            exp_rd++;
          end
        end
        dp = ap; w = 0; i++;
      end else begin
        w++;
        if (w > 3) begin
          check("stall_bound", 32'(w), 32'd1);
          i = seq.size() + 1;
        end
      end
    end
  endtask
  initial begin
    xfer_t x;
    int r;
    for (int k = 0; k < 2**AW; k++) mem[k] = '0;
    for (int k = 0; k < REGION; k++) ref_mem[k] = '0;
    drive(IDLE_X, IDLE_X);
    repeat (2) @(posedge hclk);
    #1;
    check("rst_ready", 32'(bus.hready_resp), 32'd1);
    check("rst_resp", 32'(bus.hresp), 32'd0);
    check("rst_rdata", bus.hrdata, 32'd0);
    check("rst_cswe", 32'({sram_cs, sram_we}), 32'd0);
    check("rst_be_addr", 32'({sram_be, sram_addr}), 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    seq = {};
    seq.push_back(mk(1, 2, 32'h10, 32'hDEADBEEF));
    seq.push_back(mk(0, 2, 32'h10, 32'h0));
    seq.push_back(mk(1, 0, 32'h21, 32'h1111_1111));
    seq.push_back(mk(1, 0, 32'h22, 32'h2222_2222));
    seq.push_back(mk(0, 2, 32'h20, 32'h0));
    seq.push_back(mk(0, 2, 32'h40, 32'h0, 2'b10));
    seq.push_back(mk(0, 2, 32'h44, 32'h0, 2'b11));
    seq.push_back(mk(0, 2, 32'h48, 32'h0, 2'b11));
    seq.push_back(mk(0, 2, 32'h4C, 32'h0, 2'b11));
    seq.push_back(mk(1, 1, 32'h03, 32'h0));
    seq.push_back(mk(0, 2, 32'h04, 32'h0));
    seq.push_back(mk(0, 3, 32'h40, 32'h0, 2'b01));
    seq.push_back(mk(1, 2, 32'h80, 32'h1234_5678));
    run_seq();
    seq = {};
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 9));
      x.sel = $urandom_range(0, 9) != 0;
      x.trans = r < 1 ? 2'b00 : r < 2 ? 2'b01 : r < 6 ? 2'b10 : 2'b11;
      x.wr = 1'($urandom_range(0, 1));
      x.size = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      x.addr = $urandom_range(0, 127);
      if ($urandom_range(0, 4) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 1);
      if ($urandom_range(0, 7) == 0) x.addr[31:AW+2] = 16'($urandom);
      x.data = $urandom;
      seq.push_back(x);
    end
    run_seq();
    drive(mk(1, 2, 32'h80, 32'h0), IDLE_X);
    @(posedge hclk);
    #1;
    drive(IDLE_X, mk(1, 2, 32'h80, 32'hCAFE_F00D));
    #2;
    check("rstmid_pre_cswe", 32'({sram_cs, sram_we}), 32'd3);
    hresetn = 1'b0;
    #1;
    check("rstmid_cswe", 32'({sram_cs, sram_we}), 32'd0);
    check("rstmid_ready", 32'(bus.hready_resp), 32'd1);
    check("rstmid_resp", 32'(bus.hresp), 32'd0);
    check("rstmid_wdata", sram_wdata, 32'd0);
    @(posedge hclk);
    #2;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    seq = {};
    seq.push_back(mk(0, 2, 32'h80, 32'h0));
    run_seq();
    check("sram_writes", 32'(got_wr), 32'(exp_wr));
    check("sram_reads", 32'(got_rd), 32'(exp_rd));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
